// File: rtl/output_deskewer.sv
// Receive-side deskew for the systolic array: realigns column-staggered outputs into whole rows,
// buffers them in a small FIFO and hands them out over valid/ready with per-matrix done pulses.
module output_deskewer #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  skewed_in,
  input  logic                                   skewed_valid,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]  row_out,
  output logic                                   row_valid,
  input  logic                                   row_ready,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
  output logic                                   matrix_done,
  output logic                                   overflow
);

  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = AddrW + 1;
  localparam int unsigned CntW   = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  localparam logic [CntW-1:0]   LastRow   = CntW'(MATRIX_SIZE - 1);
  localparam logic [LevelW-1:0] FullLevel = LevelW'(FIFO_DEPTH);

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] row_t;

  row_t aligned_row;
  logic aligned_valid;

  // Column i arrives i cycles late, so it is held for the remaining MATRIX_SIZE-1-i cycles.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_col
    localparam int Stages = int'(MATRIX_SIZE) - 1 - i;
    if (Stages == 0) begin : g_pass
      assign aligned_row[i] = skewed_in[i];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] dly_q [Stages];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < Stages; k++) begin
            dly_q[k] <= '0;
          end
        end else begin
          dly_q[0] <= skewed_in[i];
          for (int k = 1; k < Stages; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
      end
      assign aligned_row[i] = dly_q[Stages-1];
    end
  end

  if (MATRIX_SIZE == 1) begin : g_vld_pass
    assign aligned_valid = skewed_valid;
  end else begin : g_vld_pipe
    logic [MATRIX_SIZE-2:0] vld_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= skewed_valid;
        for (int k = 1; k < int'(MATRIX_SIZE) - 1; k++) begin
          vld_q[k] <= vld_q[k-1];
        end
      end
    end
    assign aligned_valid = vld_q[MATRIX_SIZE-2];
  end

  row_t              mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [CntW-1:0]   row_cnt_q, row_cnt_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  logic full, pop, push, drop;

  assign row_valid = (level_q != '0);
  assign full      = (level_q == FullLevel);
  assign pop       = row_valid & row_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the row.
  assign push      = aligned_valid & (~full | pop);
  assign drop      = aligned_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= aligned_row;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + AddrW'(push);
    rd_ptr_d   = rd_ptr_q + AddrW'(pop);
    level_d    = level_q;
    row_cnt_d  = row_cnt_q;
    done_d     = 1'b0;
    overflow_d = overflow_q | drop;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase

    if (pop) begin
      if (row_cnt_q == LastRow) begin
        row_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      row_cnt_q  <= row_cnt_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Head entry is masked when empty so row_out reads zero out of reset.
  assign row_out     = row_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level  = level_q;
  assign matrix_done = done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_output_deskewer.sv
// Scoreboard bench for output_deskewer: a 2x2 instance checked by a queue-based monitor,
// plus a MATRIX_SIZE=1 instance exercised with directed checks.
module tb_output_deskewer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 2x2 instance
  logic [1:0][31:0] skewed_in = '0;
  logic             skewed_valid = 1'b0;
  logic [1:0][31:0] row_out;
  logic             row_valid;
  logic             row_ready = 1'b0;
  logic [2:0]       fifo_level;
  logic             matrix_done;
  logic             overflow;

  output_deskewer #(.MATRIX_SIZE(2), .DATA_SIZE(32), .FIFO_DEPTH(4)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .skewed_in    (skewed_in),
    .skewed_valid (skewed_valid),
    .row_out      (row_out),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .fifo_level   (fifo_level),
    .matrix_done  (matrix_done),
    .overflow     (overflow)
  );

  // 1x1 instance
  logic [0:0][31:0] m1_in = '0;
  logic             m1_valid = 1'b0;
  logic [0:0][31:0] m1_row_out;
  logic             m1_row_valid;
  logic             m1_ready = 1'b1;
  logic [2:0]       m1_level;
  logic             m1_done;
  logic             m1_ovf;

  output_deskewer #(.MATRIX_SIZE(1), .DATA_SIZE(32), .FIFO_DEPTH(4)) u_m1 (
    .clk          (clk),
    .reset        (reset),
    .skewed_in    (m1_in),
    .skewed_valid (m1_valid),
    .row_out      (m1_row_out),
    .row_valid    (m1_row_valid),
    .row_ready    (m1_ready),
    .fifo_level   (m1_level),
    .matrix_done  (m1_done),
    .overflow     (m1_ovf)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passes++;
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard: expected rows as {col1, col0}
  logic [63:0] exp_q[$];
  int          pop_cyc[$];
  int          pop_cnt = 0;
  logic        exp_done = 1'b0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    logic nxt;
    logic [63:0] e;
    if (!reset) begin
      pop_cnt  = 0;
      exp_done = 1'b0;
    end else begin
      if (matrix_done || exp_done) check("matrix_done", 64'(matrix_done), 64'(exp_done));
      if (matrix_done) done_cnt++;
      nxt = 1'b0;
      if (row_valid && row_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          fail_now($sformatf("unexpected_row got 0x%0h", row_out));
        end else begin
          e = exp_q.pop_front();
          check("row_data", row_out, e);
        end
        nxt     = (pop_cnt == 1);
        pop_cnt = (pop_cnt + 1) % 2;
      end
      exp_done = nxt;
    end
  end

  task automatic drive(input logic v, input logic [31:0] c0, input logic [31:0] c1);
    @(posedge clk);
    #1;
    skewed_valid = v;
    skewed_in[0] = c0;
    skewed_in[1] = c1;
  endtask

  // n rows (b0+r, b1+r) back to back; the first nexp are expected at the output.
  task automatic stream(input int n, input logic [31:0] b0, input logic [31:0] b1,
                        input int nexp, output int t0);
    t0 = 0;
    for (int k = 0; k <= n; k++) begin
      drive(k < n, (k < n) ? b0 + 32'(k) : 32'h0, (k > 0) ? b1 + 32'(k - 1) : 32'h0);
      if (k == 0) t0 = cyc;
      if (k < nexp) exp_q.push_back({b1 + 32'(k), b0 + 32'(k)});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || row_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, d0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done", 64'(matrix_done), 64'd0);
    check("rst_row_out", row_out, 64'd0);
    check("rst_m1_valid", 64'(m1_row_valid), 64'd0);
    #2 reset = 1'b1;

    // Single row: valid at t0, row visible at t0+2
    row_ready = 1'b1;
    stream(1, 32'h11, 32'h22, 1, t0);
    @(negedge clk);
    check("single_not_early", 64'(row_valid), 64'd0);
    @(negedge clk);
    check("single_valid", 64'(row_valid), 64'd1);
    check("single_level1", 64'(fifo_level), 64'd1);
    check("single_data", row_out, {32'h22, 32'h11});
    @(negedge clk);
    check("single_level0", 64'(fifo_level), 64'd0);
    drain();

    // Streaming: 4 rows, one per cycle
    pop_cyc.delete();
    d0 = done_cnt;
    stream(4, 32'h10, 32'h20, 4, t0);
    drain();
    check("stream_pops", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4) begin
      check("stream_first_cyc", 64'(pop_cyc[0]), 64'(t0 + 2));
      check("stream_last_cyc", 64'(pop_cyc[3]), 64'(t0 + 5));
    end
    check("stream_done_pulses", 64'(done_cnt - d0), 64'd2);

    // Backpressure, then overflow on a 5th row
    row_ready = 1'b0;
    stream(4, 32'h30, 32'h40, 4, t0);
    repeat (2) @(negedge clk);
    check("bp_level_full", 64'(fifo_level), 64'd4);
    check("bp_no_overflow", 64'(overflow), 64'd0);
    stream(1, 32'h99, 32'h99, 0, t1);
    repeat (2) @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_level", 64'(fifo_level), 64'd4);
    row_ready = 1'b1;
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    pulse_reset();
    check("rst2_overflow", 64'(overflow), 64'd0);
    row_ready = 1'b0;
    stream(4, 32'h50, 32'h60, 4, t0);
    repeat (2) @(negedge clk);
    check("pp_level_full", 64'(fifo_level), 64'd4);
    drive(1'b1, 32'h55, 32'h0);
    exp_q.push_back({32'h65, 32'h55});
    drive(1'b0, 32'h0, 32'h65);
    row_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    row_ready = 1'b0;
    @(negedge clk);
    check("pp_level", 64'(fifo_level), 64'd4);
    check("pp_no_overflow", 64'(overflow), 64'd0);
    row_ready = 1'b1;
    drain();

    // Reset mid-operation: 2 buffered, 1 in flight
    row_ready = 1'b0;
    stream(3, 32'h70, 32'h80, 0, t0);
    check("mid_level_before", 64'(fifo_level), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_row_valid", 64'(row_valid), 64'd0);
    check("mid_level", 64'(fifo_level), 64'd0);
    check("mid_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    row_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_inflight_gone", 64'(row_valid), 64'd0);
    d0 = done_cnt;
    stream(2, 32'hA0, 32'hB0, 2, t0);
    drain();
    check("mid_done_after_two", 64'(done_cnt - d0), 64'd1);

    // MATRIX_SIZE=1: row at t+1, done after every pop
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      m1_valid = 1'b1;
      m1_in[0] = 32'h77 + 32'(r);
      @(negedge clk);
      check("m1_not_early", 64'(m1_row_valid), 64'd0);
      @(posedge clk);
      #1;
      m1_valid = 1'b0;
      @(negedge clk);
      check("m1_valid", 64'(m1_row_valid), 64'd1);
      check("m1_data", 64'(m1_row_out), 64'(32'h77 + 32'(r)));
      @(negedge clk);
      check("m1_done", 64'(m1_done), 64'd1);
      check("m1_empty", 64'(m1_row_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/output_deskewer.md
Name: output_deskewer

Overview:
- Receive end of the systolic datapath; mirror of the input skew stage.
- Takes the column-staggered partial-sum outputs of the systolic array, where column i of a row arrives i cycles after column 0, and realigns them into whole rows.
- Buffers aligned rows in a small FIFO and presents them over a valid/ready interface.
- Counts delivered rows and pulses a per-matrix done flag.

Parameters:
- MATRIX_SIZE, 2, number of columns per row and rows per matrix (>=1).
- DATA_SIZE, 32, bit width of each element.
- FIFO_DEPTH, 4, aligned-row buffer depth in rows (power of two, >=2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- skewed_in  input  [DATA_SIZE-1:0] x MATRIX_SIZE  staggered column outputs from the array.
- skewed_valid  input  1  high in the cycle column 0 of a row is valid on skewed_in[0].
- row_out  output  [DATA_SIZE-1:0] x MATRIX_SIZE  aligned row at FIFO head.
- row_valid  output  1  FIFO non-empty; row_out is valid.
- row_ready  input  1  consumer accepts the head row when row_valid && row_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  rows currently buffered.
- matrix_done  output  1  one-cycle pulse when the MATRIX_SIZE-th row of a matrix is popped.
- overflow  output  1  sticky: an aligned row was dropped because the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous) clears the following; no other state is cleared.
  - All delay registers and the valid pipeline.
  - FIFO pointers; fifo_level=0; row_valid=0.
  - row_out=0, matrix_done=0, overflow=0.
  - Row counter=0.
- Reset asserted mid-operation discards in-flight and buffered rows. The first row after deassertion is treated as row 0 of a new matrix.
- Deskew:
  - Column i passes through MATRIX_SIZE-1-i registers. Column MATRIX_SIZE-1 is unregistered.
  - skewed_valid passes through a MATRIX_SIZE-1 stage shift register.
  - With MATRIX_SIZE=1 there are no delay stages.
- Alignment:
  - A row whose skewed_valid is high in cycle t is aligned in cycle t+MATRIX_SIZE-1.
  - It is written into the FIFO at the closing edge of that cycle.
- Latency: row_valid rises in cycle t+MATRIX_SIZE if the FIFO was empty. There is no bypass path.
- Back-to-back rows: skewed_valid may be high every cycle; full throughput is one row per cycle.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - row_out is driven from the head entry.
  - Pop occurs when row_valid && row_ready.
  - row_ready while empty has no effect.
- Push/pop interaction:
  - Simultaneous push and pop: both occur, level unchanged. This holds when full too: the pop frees the slot, and the push is accepted without overflow.
  - Push while full with no pop: row is dropped, overflow set (sticky until reset), FIFO contents unchanged.
- fifo_level is registered and reflects the state after the last edge.
- Row counter:
  - Increments on each pop.
  - When it reaches MATRIX_SIZE-1 and a pop occurs, it wraps to 0 and matrix_done pulses high for the next cycle.
  - Dropped rows are not counted.
- Arithmetic: data passes through unmodified; no width change, no saturation.

Test Plan:
- Single row, MATRIX_SIZE=2, DATA_SIZE=32:
  - Stimulus: skewed_valid at cycle 5, skewed_in[0]=0x11 at cycle 5, skewed_in[1]=0x22 at cycle 6, row_ready=1.
  - Required: row_valid high in cycle 7 with row_out={0x11,0x22}; fifo_level=1 then 0.
- Streaming:
  - Stimulus: 4 consecutive rows (0x10+r, 0x20+r) with row_ready=1.
  - Required: 4 rows in order on consecutive cycles starting 2 cycles after the first skewed_valid; matrix_done pulses twice (after rows 1 and 3).
- Backpressure/full:
  - Stimulus: row_ready=0, push 4 rows.
  - Required: fifo_level=4, overflow=0.
  - Stimulus: push a 5th row.
  - Required: overflow=1, level stays 4; draining yields rows 0–3 only.
- Full with simultaneous push/pop:
  - Stimulus: fill to 4, then assert row_ready in the same cycle a 5th aligned row arrives.
  - Required: level stays 4, overflow=0, 5th row later delivered.
- Reset mid-operation:
  - Stimulus: 2 rows buffered plus 1 in flight, pulse reset low asynchronously.
  - Required: row_valid=0, fifo_level=0, overflow=0 immediately; the in-flight row never appears.
  - Follow-on: next matrix's matrix_done occurs after MATRIX_SIZE new pops.
- MATRIX_SIZE=1:
  - Stimulus: skewed_valid at cycle t.
  - Required: row_valid at t+1; matrix_done pulses after every pop.
